fft_r2_controller: RTL



---
 rtl/fft_r2_controller.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_r2_controller.sv
// fft_r2_controller: in-place radix-2 DIT FFT sequencer.
// Walks LOG2N stages of N/2 butterflies. It issues read-address pairs and
// twiddle indices, and delays them by D = RD_LATENCY + BFU_LATENCY to form
// write-back addresses. D drain cycles between stages keep stage s+1 reads
// behind the last stage s write.
// Optional feature: define FFT_CTRL_BITREV_EN to build a LOAD phase that
// writes incoming samples to bit-reversed addresses before the first stage.
//
// Handshake: start is a level sampled only in IDLE. ld_valid qualifies one
// sample per cycle during LOAD; there is no backpressure, and ld_wr_en
// mirrors ld_valid combinationally while in LOAD.
module fft_r2_controller #(
    parameter int LOG2N       = 4,
    parameter int RD_LATENCY  = 1,
    parameter int BFU_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       rd_en,
    output logic [LOG2N-1:0]           rd_addr_a,
    output logic [LOG2N-1:0]           rd_addr_b,
    output logic [LOG2N-2:0]           tw_addr,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_a,
    output logic [LOG2N-1:0]           wr_addr_b,
    input  logic                       ld_valid,
    output logic                       ld_wr_en,
    output logic [LOG2N-1:0]           ld_addr
);
    localparam int SW  = $clog2(LOG2N);
    localparam int D   = RD_LATENCY + BFU_LATENCY;
    localparam int DCW = $clog2(D + 1);
    localparam logic [LOG2N-2:0] KMAX       = '1;
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(D - 1);

    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             en;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } wb_t;

    // Insert a 0 at bit s of the butterfly counter to form the A operand.
    function automatic logic [LOG2N-1:0] addr_a_of(input logic [LOG2N-2:0] k,
                                                   input logic [SW-1:0]    s);
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] lo_mask;
        kx      = {1'b0, k};
        lo_mask = (LOG2N'(1) << s) - LOG2N'(1);
        return ((kx & ~lo_mask) << 1) | (kx & lo_mask);
    endfunction

    // Twiddle index (k mod 2^s) scaled to the N-point ROM.
    function automatic logic [LOG2N-2:0] tw_of(input logic [LOG2N-2:0] k,
                                               input logic [SW-1:0]    s);
        logic [LOG2N-2:0] m;
        m = ((LOG2N-1)'(1) << s) - (LOG2N-1)'(1);
        return (k & m) << ((LOG2N - 1) - int'(s));
    endfunction

    state_t           state_q, state_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic             busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
    logic [LOG2N-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [LOG2N-2:0] tw_q, tw_d;
    wb_t              wb_q [D];
    wb_t              wb_d [D];
`ifdef FFT_CTRL_BITREV_EN
    logic [LOG2N-1:0] ld_cnt_q, ld_cnt_d;
`endif

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        dcnt_d  = dcnt_q;
`ifdef FFT_CTRL_BITREV_EN
        ld_cnt_d = ld_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d     = '0;
                    stage_d = '0;
`ifdef FFT_CTRL_BITREV_EN
                    state_d  = LOAD;
                    ld_cnt_d = '0;
`else
                    state_d = READ;
`endif
                end
            end
            LOAD: begin
`ifdef FFT_CTRL_BITREV_EN
                if (ld_valid) begin
                    if (ld_cnt_q == LOG2N'((1 << LOG2N) - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = READ;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LOG2N'(1);
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            READ: begin
                if (k_q == KMAX) begin
                    k_d     = '0;
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + (LOG2N-1)'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == DRAIN_LAST) begin
                    dcnt_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = READ;
                    end
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == LOAD) || (state_d == READ) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
        rd_en_d = (state_d == READ);
        rd_a_d  = '0;
        rd_b_d  = '0;
        tw_d    = '0;
        if (rd_en_d) begin
            rd_a_d = addr_a_of(k_d, stage_d);
            rd_b_d = rd_a_d | (LOG2N'(1) << stage_d);
            tw_d   = tw_of(k_d, stage_d);
        end
    end

    // Write-back delay line: wr_* is rd_* exactly D cycles later.
    always_comb begin
        wb_d[0] = '{en: rd_en_q, a: rd_a_q, b: rd_b_q};
        for (int i = 1; i < D; i++) begin
            wb_d[i] = wb_q[i-1];
        end
    end

    // State, counter, output and delay-line registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            k_q     <= '0;
            stage_q <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            for (int i = 0; i < D; i++) wb_q[i] <= '0;
`ifdef FFT_CTRL_BITREV_EN
            ld_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
            for (int i = 0; i < D; i++) wb_q[i] <= wb_d[i];
`ifdef FFT_CTRL_BITREV_EN
            ld_cnt_q <= ld_cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr   = tw_q;
    assign wr_en     = wb_q[D-1].en;
    assign wr_addr_a = wb_q[D-1].a;
    assign wr_addr_b = wb_q[D-1].b;

`ifdef FFT_CTRL_BITREV_EN
    logic [LOG2N-1:0] ld_rev;

    // Bit-reversed load address from the sample counter.
    always_comb begin
        ld_rev = '0;
        for (int i = 0; i < LOG2N; i++) ld_rev[i] = ld_cnt_q[LOG2N-1-i];
    end

    assign ld_wr_en = (state_q == LOAD) && ld_valid;
    assign ld_addr  = (state_q == LOAD) ? ld_rev : '0;
`else
    logic unused_ld_valid;
    assign unused_ld_valid = ld_valid;
    assign ld_wr_en        = 1'b0;
    assign ld_addr         = '0;
`endif
endmodule
